// File: rtl/softmax_row_packer.sv
// rtl/softmax_row_packer.sv - ping-pong row buffer that packs softmax bytes into bus words
// A byte stream with no backpressure fills one bank while the other drains over ready/valid.
module softmax_row_packer #(
   parameter int SOFTMAX_NUM = 64,
   parameter int GBUS_DATA   = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [7:0]           in_data,
   input  logic                 in_valid,
   output logic [GBUS_DATA-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic [1:0]           buf_level,
   output logic                 overflow,
   input  logic                 overflow_clr
);
   localparam int BYTES_PER_WORD = GBUS_DATA / 8;
   localparam int WORDS_PER_ROW  = (SOFTMAX_NUM + BYTES_PER_WORD - 1) / BYTES_PER_WORD;
   localparam int CW = (SOFTMAX_NUM > 1) ? $clog2(SOFTMAX_NUM) : 1;
   localparam int RW = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(SOFTMAX_NUM - 1);
   localparam logic [RW-1:0] WORD_LAST = RW'(WORDS_PER_ROW - 1);

   logic [7:0]           bank_q [2][SOFTMAX_NUM];
   logic                 wr_sel_q, wr_sel_d;
   logic                 rd_sel_q, rd_sel_d;
   logic [CW-1:0]        wr_cnt_q, wr_cnt_d;
   logic [RW-1:0]        rd_word_q, rd_word_d;
   logic [1:0]           full_q, full_d;
   logic                 overflow_q, overflow_d;
   logic                 rd_fire, rd_free, wr_en;
   logic [GBUS_DATA-1:0] word_c;
   int                   idx;

   always_comb begin
      out_valid = full_q[rd_sel_q];
      out_last  = out_valid && (rd_word_q == WORD_LAST);
      rd_fire   = out_valid && out_ready;
      rd_free   = rd_fire && out_last;
      // A full write bank may still take a byte if its last word leaves this cycle
      wr_en     = in_valid && (!full_q[wr_sel_q] || (rd_free && (rd_sel_q == wr_sel_q)));
      buf_level = {1'b0, full_q[0]} + {1'b0, full_q[1]};
      overflow  = overflow_q;
      out_data  = out_valid ? word_c : '0;
   end

   always_comb begin
      word_c = '0;
      idx    = 0;
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
         idx = int'(rd_word_q) * BYTES_PER_WORD + k;
         if (idx < SOFTMAX_NUM) word_c[8*k +: 8] = bank_q[rd_sel_q][CW'(idx)];
      end
   end

   always_comb begin
      wr_sel_d   = wr_sel_q;
      rd_sel_d   = rd_sel_q;
      wr_cnt_d   = wr_cnt_q;
      rd_word_d  = rd_word_q;
      full_d     = full_q;
      overflow_d = overflow_q;
      if (rd_fire) begin
         if (out_last) begin
            rd_word_d        = '0;
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
         end else begin
            rd_word_d = rd_word_q + RW'(1);
         end
      end
      // Fill is applied after free so a one-byte row can free and refill one bank
      if (wr_en) begin
         if (wr_cnt_q == CNT_LAST) begin
            wr_cnt_d         = '0;
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
         end else begin
            wr_cnt_d = wr_cnt_q + CW'(1);
         end
      end
      if (overflow_clr) overflow_d = 1'b0;
      if (in_valid && !wr_en) overflow_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (wr_en) bank_q[wr_sel_q][wr_cnt_q] <= in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_sel_q   <= 1'b0;
         rd_sel_q   <= 1'b0;
         wr_cnt_q   <= '0;
         rd_word_q  <= '0;
         full_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_sel_q   <= wr_sel_d;
         rd_sel_q   <= rd_sel_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_word_q  <= rd_word_d;
         full_q     <= full_d;
         overflow_q <= overflow_d;
      end
   end
endmodule

// File: tb/tb_softmax_row_packer.sv
// tb/tb_softmax_row_packer.sv - directed and random-stall bench for softmax_row_packer
// u_dut uses 8-byte rows, u_pad uses 10-byte rows so the last word carries zero padding.
module tb_softmax_row_packer;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  in_data, p_in_data;
   logic        in_valid, p_in_valid;
   logic [31:0] out_data, p_out_data;
   logic        out_valid, p_out_valid;
   logic        out_ready, p_out_ready;
   logic        out_last, p_out_last;
   logic [1:0]  buf_level, p_buf_level;
   logic        overflow, p_overflow;
   logic        overflow_clr, p_overflow_clr;
   int          pass_cnt = 0;
   int          total_cnt = 0;

   always #5 clk = ~clk;

   softmax_row_packer #(.SOFTMAX_NUM(8), .GBUS_DATA(32)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .buf_level(buf_level), .overflow(overflow),
      .overflow_clr(overflow_clr));

   softmax_row_packer #(.SOFTMAX_NUM(10), .GBUS_DATA(32)) u_pad (
      .clk(clk), .rst_n(rst_n), .in_data(p_in_data), .in_valid(p_in_valid),
      .out_data(p_out_data), .out_valid(p_out_valid), .out_ready(p_out_ready),
      .out_last(p_out_last), .buf_level(p_buf_level), .overflow(p_overflow),
      .overflow_clr(p_overflow_clr));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 0; in_data = 0; out_ready = 0; overflow_clr = 0;
      p_in_valid = 0; p_in_data = 0; p_out_ready = 0; p_overflow_clr = 0;
      tick(); tick();
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %0b exp 0", out_valid); else pass_cnt++;
      total_cnt++; if (out_last !== 1'b0) $display("FAIL rst_last got %0b exp 0", out_last); else pass_cnt++;
      total_cnt++; if (out_data !== 32'h0) $display("FAIL rst_data got %h exp 0", out_data); else pass_cnt++;
      total_cnt++; if (buf_level !== 2'd0) $display("FAIL rst_level got %0d exp 0", buf_level); else pass_cnt++;
      total_cnt++; if (overflow !== 1'b0) $display("FAIL rst_ovf got %0b exp 0", overflow); else pass_cnt++;
      total_cnt++; if (p_out_valid !== 1'b0) $display("FAIL rst_pad_valid got %0b exp 0", p_out_valid); else pass_cnt++;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic_row();
      out_ready = 1;
      for (int i = 0; i < 8; i++) begin
         total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid byte %0d got %0b exp 0", i, out_valid); else pass_cnt++;
         in_valid = 1; in_data = 8'(i + 1);
         tick();
      end
      in_valid = 0;
      total_cnt++; if ({out_valid, out_last, out_data} !== {2'b10, 32'h04030201}) $display("FAIL basic_w0 got v%0b l%0b %h exp v1 l0 04030201", out_valid, out_last, out_data); else pass_cnt++;
      tick();
      total_cnt++; if ({out_valid, out_last, out_data} !== {2'b11, 32'h08070605}) $display("FAIL basic_w1 got v%0b l%0b %h exp v1 l1 08070605", out_valid, out_last, out_data); else pass_cnt++;
      tick();
      total_cnt++; if ({out_valid, buf_level} !== 3'b000) $display("FAIL basic_done got v%0b lvl%0d exp v0 lvl0", out_valid, buf_level); else pass_cnt++;
   endtask

   task automatic test_padding();
      p_out_ready = 1;
      for (int i = 0; i < 10; i++) begin
         p_in_valid = 1; p_in_data = 8'(8'h11 + i);
         tick();
      end
      p_in_valid = 0;
      total_cnt++; if ({p_out_valid, p_out_last, p_out_data} !== {2'b10, 32'h14131211}) $display("FAIL pad_w0 got v%0b l%0b %h exp v1 l0 14131211", p_out_valid, p_out_last, p_out_data); else pass_cnt++;
      tick();
      total_cnt++; if ({p_out_valid, p_out_last, p_out_data} !== {2'b10, 32'h18171615}) $display("FAIL pad_w1 got v%0b l%0b %h exp v1 l0 18171615", p_out_valid, p_out_last, p_out_data); else pass_cnt++;
      tick();
      total_cnt++; if ({p_out_valid, p_out_last, p_out_data} !== {2'b11, 32'h00001A19}) $display("FAIL pad_w2 got v%0b l%0b %h exp v1 l1 00001a19", p_out_valid, p_out_last, p_out_data); else pass_cnt++;
      tick();
      total_cnt++; if (p_out_valid !== 1'b0) $display("FAIL pad_done got %0b exp 0", p_out_valid); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      out_ready = 0;
      for (int i = 0; i < 16; i++) begin
         in_valid = 1; in_data = 8'(8'h20 + i);
         tick();
      end
      total_cnt++; if ({buf_level, overflow} !== 3'b100) $display("FAIL bp_level got lvl%0d ovf%0b exp lvl2 ovf0", buf_level, overflow); else pass_cnt++;
      in_data = 8'h99;
      tick();
      in_valid = 0;
      total_cnt++; if ({buf_level, overflow} !== 3'b101) $display("FAIL bp_drop got lvl%0d ovf%0b exp lvl2 ovf1", buf_level, overflow); else pass_cnt++;
      total_cnt++; if ({out_valid, out_last, out_data} !== {2'b10, 32'h23222120}) $display("FAIL bp_hold got v%0b l%0b %h exp v1 l0 23222120", out_valid, out_last, out_data); else pass_cnt++;
      out_ready = 1;
      total_cnt++; if ({out_valid, out_last, out_data} !== {2'b10, 32'h23222120}) $display("FAIL bp_w0 got v%0b l%0b %h exp v1 l0 23222120", out_valid, out_last, out_data); else pass_cnt++;
      tick();
      total_cnt++; if ({out_valid, out_last, out_data} !== {2'b11, 32'h27262524}) $display("FAIL bp_w1 got v%0b l%0b %h exp v1 l1 27262524", out_valid, out_last, out_data); else pass_cnt++;
      tick();
      total_cnt++; if ({out_valid, out_last, out_data} !== {2'b10, 32'h2B2A2928}) $display("FAIL bp_w2 got v%0b l%0b %h exp v1 l0 2b2a2928", out_valid, out_last, out_data); else pass_cnt++;
      tick();
      total_cnt++; if ({out_valid, out_last, out_data} !== {2'b11, 32'h2F2E2D2C}) $display("FAIL bp_w3 got v%0b l%0b %h exp v1 l1 2f2e2d2c", out_valid, out_last, out_data); else pass_cnt++;
      tick();
      total_cnt++; if ({out_valid, buf_level, overflow} !== 4'b0001) $display("FAIL bp_drained got v%0b lvl%0d ovf%0b exp v0 lvl0 ovf1", out_valid, buf_level, overflow); else pass_cnt++;
      overflow_clr = 1;
      tick();
      overflow_clr = 0;
      total_cnt++; if (overflow !== 1'b0) $display("FAIL bp_clr got %0b exp 0", overflow); else pass_cnt++;
   endtask

   task automatic test_same_cycle_free();
      out_ready = 0;
      for (int i = 0; i < 16; i++) begin
         in_valid = 1; in_data = 8'(8'h40 + i);
         tick();
      end
      in_valid = 0; out_ready = 1;
      tick();
      total_cnt++; if ({out_last, out_data} !== {1'b1, 32'h47464544}) $display("FAIL scf_last got l%0b %h exp l1 47464544", out_last, out_data); else pass_cnt++;
      in_valid = 1; in_data = 8'h50;
      tick();
      in_valid = 0;
      total_cnt++; if ({overflow, buf_level} !== 3'b001) $display("FAIL scf_accept got ovf%0b lvl%0d exp ovf0 lvl1", overflow, buf_level); else pass_cnt++;
      total_cnt++; if ({out_valid, out_last, out_data} !== {2'b10, 32'h4B4A4948}) $display("FAIL scf_r2w0 got v%0b l%0b %h exp v1 l0 4b4a4948", out_valid, out_last, out_data); else pass_cnt++;
      tick();
      total_cnt++; if ({out_valid, out_last, out_data} !== {2'b11, 32'h4F4E4D4C}) $display("FAIL scf_r2w1 got v%0b l%0b %h exp v1 l1 4f4e4d4c", out_valid, out_last, out_data); else pass_cnt++;
      tick();
      for (int i = 1; i < 8; i++) begin
         in_valid = 1; in_data = 8'(8'h50 + i);
         tick();
      end
      in_valid = 0;
      total_cnt++; if ({out_valid, out_last, out_data} !== {2'b10, 32'h53525150}) $display("FAIL scf_r3w0 got v%0b l%0b %h exp v1 l0 53525150", out_valid, out_last, out_data); else pass_cnt++;
      tick();
      total_cnt++; if ({out_valid, out_last, out_data} !== {2'b11, 32'h57565554}) $display("FAIL scf_r3w1 got v%0b l%0b %h exp v1 l1 57565554", out_valid, out_last, out_data); else pass_cnt++;
      tick();
      total_cnt++; if ({out_valid, overflow} !== 2'b00) $display("FAIL scf_done got v%0b ovf%0b exp v0 ovf0", out_valid, overflow); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 13; i++) begin
         out_ready = (i == 8);
         in_valid = 1; in_data = 8'(8'h60 + i);
         tick();
      end
      in_valid = 0; out_ready = 0;
      total_cnt++; if ({out_valid, out_last, out_data} !== {2'b11, 32'h67666564}) $display("FAIL rm_half got v%0b l%0b %h exp v1 l1 67666564", out_valid, out_last, out_data); else pass_cnt++;
      rst_n = 0;
      #1;
      total_cnt++; if ({out_valid, out_last, out_data, buf_level, overflow} !== 37'h0) $display("FAIL rm_outputs got v%0b l%0b %h lvl%0d ovf%0b exp all 0", out_valid, out_last, out_data, buf_level, overflow); else pass_cnt++;
      tick(); tick();
      rst_n = 1;
      out_ready = 1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1; in_data = 8'(8'h70 + i);
         tick();
      end
      in_valid = 0;
      total_cnt++; if ({out_valid, out_last, out_data} !== {2'b10, 32'h73727170}) $display("FAIL rm_w0 got v%0b l%0b %h exp v1 l0 73727170", out_valid, out_last, out_data); else pass_cnt++;
      tick();
      total_cnt++; if ({out_valid, out_last, out_data} !== {2'b11, 32'h77767574}) $display("FAIL rm_w1 got v%0b l%0b %h exp v1 l1 77767574", out_valid, out_last, out_data); else pass_cnt++;
      tick();
      total_cnt++; if ({out_valid, buf_level} !== 3'b000) $display("FAIL rm_done got v%0b lvl%0d exp v0 lvl0", out_valid, buf_level); else pass_cnt++;
   endtask

   task automatic test_random_stream();
      logic [7:0]  exp_q[$];
      logic [31:0] exp_w;
      logic [7:0]  b;
      int sent = 0;
      int words = 0;
      int cyc = 0;
      int phase = 0;
      while ((sent < 800 || exp_q.size() != 0) && cyc < 20000) begin
         out_ready = 1'($urandom_range(0, 1));
         if (out_valid && out_ready) begin
            total_cnt++;
            if (exp_q.size() < 4) begin
               $display("FAIL rand_extra_word got %h exp no word", out_data);
            end else begin
               exp_w = {exp_q[3], exp_q[2], exp_q[1], exp_q[0]};
               if ({out_last, out_data} !== {words[0], exp_w})
                  $display("FAIL rand_word %0d got l%0b %h exp l%0b %h", words, out_last, out_data, words[0], exp_w);
               else pass_cnt++;
               repeat (4) void'(exp_q.pop_front());
            end
            words++;
         end
         in_valid = (phase == 0) && (sent < 800);
         if (in_valid) begin
            b = 8'($urandom);
            in_data = b;
            exp_q.push_back(b);
            sent++;
         end
         phase = (phase == 2) ? 0 : phase + 1;
         tick();
         cyc++;
      end
      in_valid = 0; out_ready = 0;
      total_cnt++; if (words !== 200) $display("FAIL rand_word_count got %0d exp 200", words); else pass_cnt++;
      total_cnt++; if (exp_q.size() !== 0) $display("FAIL rand_leftover got %0d exp 0", exp_q.size()); else pass_cnt++;
      total_cnt++; if (overflow !== 1'b0) $display("FAIL rand_ovf got %0b exp 0", overflow); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic_row();
      test_padding();
      test_backpressure();
      test_same_cycle_free();
      test_reset_mid();
      test_random_stream();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/softmax_row_packer.md
Name: softmax_row_packer

Overview:
Downstream stage of the softmax unit. Captures the 8-bit probability stream (`odata`/`odata_valid`) one score row of SOFTMAX_NUM bytes at a time in a ping-pong buffer. Packs each completed row into GBUS_DATA-wide words and hands them to the global bus / attention-V datapath over a ready/valid handshake. The softmax output has no backpressure, so this block absorbs it and flags overflow.

Parameters:
- SOFTMAX_NUM, 64, bytes per row (context length); must be ≥ 1.
- GBUS_DATA, 64, output word width in bits; must be a multiple of 8.
- BYTES_PER_WORD, GBUS_DATA/8, derived; not overridden.
- WORDS_PER_ROW, ceil(SOFTMAX_NUM/BYTES_PER_WORD), derived.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  8  softmax probability byte.
- in_valid  input  1  in_data valid this cycle; no ready returned.
- out_data  output  GBUS_DATA  packed word; byte k at bits [8k+7:8k].
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts the word.
- out_last  output  1  high with the final word of a row.
- buf_level  output  2  number of complete rows held (0..2).
- overflow  output  1  sticky; a byte was dropped.
- overflow_clr  input  1  synchronous clear of overflow.

Behaviour:
- Storage is two banks of SOFTMAX_NUM bytes each. State is:
  - `wr_sel`, `rd_sel`: 1 bit each.
  - `wr_cnt`: 0..SOFTMAX_NUM-1.
  - `rd_word`: 0..WORDS_PER_ROW-1.
  - `full[1:0]`.
- Reset (asynchronous) clears `wr_sel`, `rd_sel`, `wr_cnt`, `rd_word`, `full` and `overflow`. Outputs after reset: `out_valid`=0, `out_last`=0, `out_data`=0, `buf_level`=0, `overflow`=0. Bank contents are not reset. Reset asserted mid-row or mid-drain discards all partial and complete rows.
- Write side:
  - A byte is accepted when `in_valid`=1 and either `full[wr_sel]`=0, or bank `wr_sel` is being freed this same cycle (its last-word handshake occurs).
  - An accepted byte is written to `bank[wr_sel][wr_cnt]` and `wr_cnt` increments.
  - When `wr_cnt`=SOFTMAX_NUM-1 is written: `full[wr_sel]`←1, `wr_cnt`←0, `wr_sel` toggles.
  - A byte that is not accepted is dropped: `wr_cnt` is unchanged and `overflow`←1.
- Read side:
  - `out_valid` = `full[rd_sel]`.
  - `out_data` = bytes `rd_word*BYTES_PER_WORD` upward of `bank[rd_sel]`. Bytes beyond SOFTMAX_NUM-1 in the final word are 0.
  - `out_data` is forced to 0 when `out_valid`=0.
  - `out_last` = `out_valid` && (`rd_word`=WORDS_PER_ROW-1).
  - A handshake (`out_valid` && `out_ready`) advances `rd_word`. On the last word: `rd_word`←0, `full[rd_sel]`←0, `rd_sel` toggles.
  - `out_data`, `out_valid` and `out_last` hold stable while `out_valid`=1 and `out_ready`=0.
- Latency: if the row's final byte is accepted at edge N, `out_valid` is high in the cycle after edge N (1 cycle). At full throughput, words stream back to back.
- `buf_level` = `full[0]` + `full[1]`.
- `overflow` is set by a dropped byte and cleared by `overflow_clr`. If both occur in the same cycle, set wins.
- Simultaneous write into a bank and free of the other bank are independent. When both banks are full and `out_ready` is held low, every incoming byte is dropped.
- Rows are emitted strictly in arrival order.

Test Plan:
- Basic row (SOFTMAX_NUM=8, GBUS_DATA=32, `out_ready`=1): bytes 0x01..0x08 on consecutive cycles → words 0x04030201 then 0x08070605, `out_last` on the second, `out_valid` first high 1 cycle after the 8th byte.
- Padding (SOFTMAX_NUM=10, GBUS_DATA=32): bytes 0x11..0x1A → 3 words, the third = 0x00001A19 with `out_last`=1.
- Backpressure (SOFTMAX_NUM=8): write 2 rows with `out_ready`=0 → `buf_level`=2. A 17th byte is dropped and `overflow`=1. Release `out_ready` → 4 words of row 1 then row 2, data unchanged. `overflow_clr` pulse → `overflow`=0.
- Same-cycle free: both banks full, first byte of a new row arrives in the cycle row 1's last word handshakes → byte accepted into the freed bank, `overflow` stays 0.
- Reset mid-operation: assert `rst_n`=0 after 5 bytes of row 2 while row 1 is half drained → all outputs 0. After release, a fresh 8-byte row is emitted correctly starting with bank 0.
- Random stall on `out_ready` (50%) over 100 continuous rows at in_valid duty ≤ 50% → no overflow; output byte stream matches input in order.
